// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// Down-counting mm:ss timer for the alarm clock. A BCD preset is loaded and
// the value counts down once per second until it reaches 00:00. At that
// point a one-cycle expiry pulse is raised, and an alarm level is held until
// it is acknowledged or a new preset is loaded.
//
// Parameters
//   TICKS_PER_SEC  clock cycles per one-second decrement (>= 2)
//   WARN_SECS      remaining seconds at or below which warn_o is raised (0..59)
//
// Ports
//   clk_i            clock, all state updates on the rising edge
//   rst_ni           asynchronous active-low reset, clears all state
//   load_i           one-cycle request to load the preset digits
//   ld_min_tens_i    preset minutes tens (0..5, larger values clamp to 5)
//   ld_min_ones_i    preset minutes ones (0..9, larger values clamp to 9)
//   ld_sec_tens_i    preset seconds tens (0..5, larger values clamp to 5)
//   ld_sec_ones_i    preset seconds ones (0..9, larger values clamp to 9)
//   start_i          begin (from IDLE) or resume (from PAUSED) counting
//   pause_i          suspend counting
//   ack_i            clear a pending alarm
//   min_tens_o ..    current BCD digits
//   sec_ones_o
//   running_o        high while in RUN
//   expired_o        one-cycle pulse after the value reaches 00:00
//   alarm_o          level set together with expired_o, held until ack/load
//   warn_o           RUN and 0 < remaining seconds <= WARN_SECS
//   state_o          current FSM state (debug visibility)
//
// Control handshake: load_i, start_i, pause_i and ack_i are single-cycle
// strobes sampled on the rising clock edge; there is no back-pressure. In the
// same cycle load beats start, and start beats pause. A load presented while
// the timer is running is dropped.
// ---------------------------------------------------------------------------
module countdown_timer #(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned WARN_SECS     = 10
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [2:0] ld_min_tens_i,
    input  logic [3:0] ld_min_ones_i,
    input  logic [2:0] ld_sec_tens_i,
    input  logic [3:0] ld_sec_ones_i,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       ack_i,
    output logic [2:0] min_tens_o,
    output logic [3:0] min_ones_o,
    output logic [2:0] sec_tens_o,
    output logic [3:0] sec_ones_o,
    output logic       running_o,
    output logic       expired_o,
    output logic       alarm_o,
    output logic       warn_o,
    output logic [1:0] state_o
);

    // Prescaler width: enough bits to hold TICKS_PER_SEC-1.
    localparam int unsigned PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [11:0]   WARN_LIMIT = 12'(WARN_SECS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    min_tens_q, min_tens_d;
    logic [3:0]    min_ones_q, min_ones_d;
    logic [2:0]    sec_tens_q, sec_tens_d;
    logic [3:0]    sec_ones_q, sec_ones_d;
    logic          expired_q, expired_d;
    logic          alarm_q, alarm_d;

    // -----------------------------------------------------------------------
    // Preset clamping
    // -----------------------------------------------------------------------
    logic [2:0] ld_mt_c;
    logic [3:0] ld_mo_c;
    logic [2:0] ld_st_c;
    logic [3:0] ld_so_c;

    always_comb begin
        ld_mt_c = (ld_min_tens_i > 3'd5) ? 3'd5 : ld_min_tens_i;
        ld_mo_c = (ld_min_ones_i > 4'd9) ? 4'd9 : ld_min_ones_i;
        ld_st_c = (ld_sec_tens_i > 3'd5) ? 3'd5 : ld_sec_tens_i;
        ld_so_c = (ld_sec_ones_i > 4'd9) ? 4'd9 : ld_sec_ones_i;
    end

    // -----------------------------------------------------------------------
    // Value status and BCD borrow chain
    // -----------------------------------------------------------------------
    logic       is_zero;
    logic       is_one;
    logic       borrow_so;
    logic       borrow_st;
    logic       borrow_mo;
    logic [2:0] dec_mt;
    logic [3:0] dec_mo;
    logic [2:0] dec_st;
    logic [3:0] dec_so;

    always_comb begin
        is_zero = (min_tens_q == 3'd0) && (min_ones_q == 4'd0) &&
                  (sec_tens_q == 3'd0) && (sec_ones_q == 4'd0);
        // 00:01 is the only value whose decrement lands on 00:00.
        is_one  = (min_tens_q == 3'd0) && (min_ones_q == 4'd0) &&
                  (sec_tens_q == 3'd0) && (sec_ones_q == 4'd1);

        borrow_so = (sec_ones_q == 4'd0);
        dec_so    = borrow_so ? 4'd9 : (sec_ones_q - 4'd1);

        borrow_st = borrow_so && (sec_tens_q == 3'd0);
        dec_st    = sec_tens_q;
        if (borrow_so) begin
            dec_st = (sec_tens_q == 3'd0) ? 3'd5 : (sec_tens_q - 3'd1);
        end

        borrow_mo = borrow_st && (min_ones_q == 4'd0);
        dec_mo    = min_ones_q;
        if (borrow_st) begin
            dec_mo = (min_ones_q == 4'd0) ? 4'd9 : (min_ones_q - 4'd1);
        end

        // Only reached with a nonzero value, so min_tens never underflows.
        dec_mt = borrow_mo ? (min_tens_q - 3'd1) : min_tens_q;
    end

    // -----------------------------------------------------------------------
    // Remaining time in seconds, used only for the warning window
    // -----------------------------------------------------------------------
    logic [11:0] total_secs;

    always_comb begin
        total_secs = (12'(min_tens_q) * 12'd600) + (12'(min_ones_q) * 12'd60) +
                     (12'(sec_tens_q) * 12'd10)  + 12'(sec_ones_q);
    end

    // -----------------------------------------------------------------------
    // Control qualifiers
    // -----------------------------------------------------------------------
    logic load_ok;
    logic tick;

    always_comb begin
        load_ok = load_i && (state_q != ST_RUN);
        // The decrement edge: prescaler at its top while running.
        tick    = (state_q == ST_RUN) && (presc_q == PRE_MAX);
    end

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_ok) begin
                    state_d = ST_IDLE;
                end else if (start_i && !is_zero) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A decrement on the pause edge still lands; reaching zero
                // takes precedence over pausing.
                if (tick && is_one) begin
                    state_d = ST_EXPIRED;
                end else if (pause_i) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (load_ok) begin
                    state_d = ST_IDLE;
                end else if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_EXPIRED: begin
                if (load_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath next state: digits, prescaler, expiry pulse, alarm
    // -----------------------------------------------------------------------
    always_comb begin
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        presc_d    = presc_q;
        expired_d  = 1'b0;
        alarm_d    = alarm_q;

        if (ack_i) begin
            alarm_d = 1'b0;
        end

        if (load_ok) begin
            min_tens_d = ld_mt_c;
            min_ones_d = ld_mo_c;
            sec_tens_d = ld_st_c;
            sec_ones_d = ld_so_c;
            presc_d    = '0;
            alarm_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !is_zero) begin
                        presc_d = '0;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        if (!is_zero) begin
                            min_tens_d = dec_mt;
                            min_ones_d = dec_mo;
                            sec_tens_d = dec_st;
                            sec_ones_d = dec_so;
                        end
                        if (is_one) begin
                            expired_d = 1'b1;
                            alarm_d   = 1'b1;
                        end
                    end else if (!pause_i) begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: begin
                    // PAUSED and EXPIRED hold everything; resuming from
                    // PAUSED keeps the prescaler where it stopped.
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q    <= '0;
            min_tens_q <= 3'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 3'd0;
            sec_ones_q <= 4'd0;
            expired_q  <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            expired_q  <= expired_d;
            alarm_q    <= alarm_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        min_tens_o = min_tens_q;
        min_ones_o = min_ones_q;
        sec_tens_o = sec_tens_q;
        sec_ones_o = sec_ones_q;
        running_o  = (state_q == ST_RUN);
        expired_o  = expired_q;
        alarm_o    = alarm_q;
        warn_o     = (state_q == ST_RUN) && (total_secs != 12'd0) &&
                     (total_secs <= WARN_LIMIT);
        state_o    = state_q;
    end

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;
  localparam int T = 4;
  localparam int W = 10;

  localparam int M_IDLE = 0;
  localparam int M_RUN = 1;
  localparam int M_PAUSED = 2;
  localparam int M_EXPIRED = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       load = 1'b0, start = 1'b0, pause = 1'b0, ack = 1'b0;
  logic [2:0] ld_mt = '0;
  logic [3:0] ld_mo = '0;
  logic [2:0] ld_st = '0;
  logic [3:0] ld_so = '0;
  logic [2:0] min_tens;
  logic [3:0] min_ones;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running, expired, alarm, warn;
  logic [1:0] state_dbg;

  countdown_timer #(.TICKS_PER_SEC(T), .WARN_SECS(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .load_i(load),
    .ld_min_tens_i(ld_mt), .ld_min_ones_i(ld_mo),
    .ld_sec_tens_i(ld_st), .ld_sec_ones_i(ld_so),
    .start_i(start), .pause_i(pause), .ack_i(ack),
    .min_tens_o(min_tens), .min_ones_o(min_ones),
    .sec_tens_o(sec_tens), .sec_ones_o(sec_ones),
    .running_o(running), .expired_o(expired), .alarm_o(alarm),
    .warn_o(warn), .state_o(state_dbg)
  );

  int total = 0;
  int bad = 0;

  // reference model: remaining time kept as plain seconds
  int m_secs, m_mode, m_pre;
  bit m_alarm, m_exp;

  function automatic int clampi(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_secs = 0; m_mode = M_IDLE; m_pre = 0; m_alarm = 0; m_exp = 0;
  endtask

  task automatic model_edge(bit l, bit s, bit p, bit a);
    m_exp = 0;
    if (l && m_mode != M_RUN) begin
      m_secs = (clampi(int'(ld_mt), 5) * 10 + clampi(int'(ld_mo), 9)) * 60 +
               clampi(int'(ld_st), 5) * 10 + clampi(int'(ld_so), 9);
      m_pre = 0; m_alarm = 0; m_mode = M_IDLE;
    end else begin
      if (a) m_alarm = 0;
      case (m_mode)
        M_IDLE: if (s && m_secs > 0) begin m_mode = M_RUN; m_pre = 0; end
        M_PAUSED: if (s) m_mode = M_RUN;
        M_RUN: begin
          if (m_pre == T - 1) begin
            m_pre = 0;
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
              m_mode = M_EXPIRED; m_exp = 1; m_alarm = 1;
            end else if (p) m_mode = M_PAUSED;
          end else if (p) m_mode = M_PAUSED;
          else m_pre = m_pre + 1;
        end
        default: ;
      endcase
    end
  endtask

  // scoreboard
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] bcd(int m, int s);
    logic [13:0] r;
    r = {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    return r;
  endfunction

  function automatic logic [13:0] dig();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic check_all(string tag);
    int mins, secs;
    mins = m_secs / 60;
    secs = m_secs % 60;
    chk({tag, ".min_tens"}, 32'(min_tens), mins / 10);
    chk({tag, ".min_ones"}, 32'(min_ones), mins % 10);
    chk({tag, ".sec_tens"}, 32'(sec_tens), secs / 10);
    chk({tag, ".sec_ones"}, 32'(sec_ones), secs % 10);
    chk({tag, ".running"}, 32'(running), 32'(m_mode == M_RUN));
    chk({tag, ".expired"}, 32'(expired), 32'(m_exp));
    chk({tag, ".alarm"}, 32'(alarm), 32'(m_alarm));
    chk({tag, ".warn"}, 32'(warn), 32'(m_mode == M_RUN && m_secs > 0 && m_secs <= W));
  endtask

  // driver tasks
  task automatic step(bit l, bit s, bit p, bit a);
    load = l; start = s; pause = p; ack = a;
    @(posedge clk);
    model_edge(l, s, p, a);
    #1;
    load = 0; start = 0; pause = 0; ack = 0;
    check_all("step");
  endtask

  task automatic set_preset(int mt, int mo, int st, int so);
    ld_mt = 3'(mt); ld_mo = 4'(mo); ld_st = 3'(st); ld_so = 4'(so);
  endtask

  task automatic load_val(int mt, int mo, int st, int so);
    set_preset(mt, mo, st, so);
    step(1, 0, 0, 0);
  endtask

  task automatic do_reset(int n);
    rst_n = 0;
    #1;
    model_reset();
    check_all("rst_async");
    repeat (n) @(posedge clk);
    #1;
    check_all("rst_hold");
    rst_n = 1;
  endtask

  initial begin
    bit seen10;
    int guard;
    model_reset();
    #2;
    do_reset(3);

    // 00:03 countdown, expiry pulse, alarm and ack
    load_val(0, 0, 0, 3);
    chk("load_0003", 32'(dig()), 32'(bcd(0, 3)));
    step(0, 1, 0, 0);
    chk("start_running", 32'(running), 1);
    for (int k = 1; k <= 14; k++) begin
      step(0, 0, 0, 0);
      if (k == 4) chk("cyc4_0002", 32'(dig()), 32'(bcd(0, 2)));
      if (k == 8) chk("cyc8_0001", 32'(dig()), 32'(bcd(0, 1)));
      if (k == 12) begin
        chk("cyc12_0000", 32'(dig()), 32'(bcd(0, 0)));
        chk("cyc12_expired", 32'(expired), 1);
        chk("cyc12_running", 32'(running), 0);
      end
      if (k == 13) begin
        chk("cyc13_expired_gone", 32'(expired), 0);
        chk("cyc13_alarm_held", 32'(alarm), 1);
      end
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("ack_clears_alarm", 32'(alarm), 0);
    step(0, 0, 0, 1);

    // borrow chains
    load_val(0, 1, 0, 0);
    step(0, 1, 0, 0);
    repeat (T) step(0, 0, 0, 0);
    chk("borrow_0100", 32'(dig()), 32'(bcd(0, 59)));
    step(0, 0, 1, 0);
    load_val(1, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (T) step(0, 0, 0, 0);
    chk("borrow_1000", 32'(dig()), 32'(bcd(9, 59)));
    step(0, 0, 1, 0);

    // pause at prescaler 2 and resume
    load_val(0, 0, 0, 5);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (10) step(0, 0, 0, 0);
    chk("paused_frozen", 32'(dig()), 32'(bcd(0, 5)));
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("resume_first", 32'(dig()), 32'(bcd(0, 5)));
    step(0, 0, 0, 0);
    chk("resume_dec", 32'(dig()), 32'(bcd(0, 4)));
    step(0, 0, 1, 0);

    // clamping and zero preset
    load_val(0, 0, 7, 12);
    chk("clamp_0059", 32'(dig()), 32'(bcd(0, 59)));
    load_val(7, 15, 0, 0);
    chk("clamp_5900", 32'(dig()), 32'(bcd(59, 0)));
    load_val(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("zero_start_idle", 32'(running), 0);
    chk("zero_start_noalarm", 32'(alarm), 0);

    // load ignored in RUN; load+start+pause in PAUSED
    load_val(0, 0, 3, 0);
    step(0, 1, 0, 0);
    set_preset(0, 3, 0, 0);
    step(1, 0, 0, 0);
    chk("load_in_run", 32'(dig()), 32'(bcd(0, 30)));
    step(0, 0, 1, 0);
    set_preset(0, 2, 0, 0);
    step(1, 1, 1, 0);
    chk("load_prio_val", 32'(dig()), 32'(bcd(2, 0)));
    chk("load_prio_idle", 32'(running), 0);

    // warn window, then reset mid-count
    load_val(0, 0, 1, 2);
    step(0, 1, 0, 0);
    seen10 = 0;
    guard = 0;
    while (m_secs > 5 && guard < 200) begin
      step(0, 0, 0, 0);
      if (m_secs == 11) chk("warn_at_11", 32'(warn), 0);
      if (m_secs == 10 && !seen10) begin
        seen10 = 1;
        chk("warn_at_10", 32'(warn), 1);
      end
      guard++;
    end
    chk("warn_loop_bound", 32'(m_secs), 5);
    do_reset(2);
    step(0, 0, 0, 0);
    chk("no_pulse_after_rst", 32'(expired), 0);

    // randomized phase
    for (int i = 0; i < 600; i++) begin
      bit l, s, p, a;
      l = ($urandom_range(0, 99) < 5);
      if (l) begin
        set_preset(($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : 0,
                   ($urandom_range(0, 4) == 0) ? 1 : 0,
                   int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 15)));
        if (ld_mt != 0) ld_mo = 4'd0;
      end
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 7) == 0);
      step(l, s, p, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
